bit_stuffer: RTL

BIT_STUFFER -- requirements
Module: bit_stuffer

---
 rtl/usb2_tx_pkg.sv | 5 +
 rtl/bit_stuffer.sv | 43 ++++
 2 files changed

// File: rtl/usb2_tx_pkg.sv
// usb2_tx_pkg: shared constants and state encodings for the USB2 TX stages
package usb2_tx_pkg;
  localparam int MAX_ONES_DEFAULT = 6;
  typedef enum logic {PASS = 1'b0, STUFF = 1'b1} stuff_state_t;
endpackage

// File: rtl/bit_stuffer.sv
// bit_stuffer: inserts a 0 after every MAX_ONES consecutive 1s while stuffing is enabled
module bit_stuffer
  import usb2_tx_pkg::*;
#(
  parameter int MAX_ONES = MAX_ONES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic din_valid,
  output logic din_ready,
  input  logic stuff_en,
  output logic dout,
  output logic dout_valid
);
  localparam int CW = $clog2(MAX_ONES + 1);
  stuff_state_t state;
  logic [CW-1:0] ones_cnt;
  logic xfer;
  assign din_ready = (state == PASS);
  assign xfer = din_valid & din_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PASS;
      ones_cnt   <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
    end else if (state == STUFF) begin
      state      <= PASS;
      ones_cnt   <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b1;
    end else begin
      dout_valid <= xfer;
      if (xfer) dout <= din;
      if (!stuff_en || (xfer && !din)) ones_cnt <= '0;
      else if (xfer) begin
        ones_cnt <= ones_cnt + 1'b1;
        state    <= (ones_cnt == CW'(MAX_ONES - 1)) ? STUFF : PASS;
      end
    end
  end
endmodule
